piezo_seq: RTL and testbench



---
 rtl/piezo_seq.sv | 153 +++++++++++++++
 tb/tb_piezo_seq.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piezo_seq.sv
// Multi-note piezo sequencer: plays seq_len entries of a DEPTH-entry tone table, with optional gap and loop.
// start -> LOAD next cycle -> TONE the cycle after; no backpressure, start while busy is dropped, stop aborts.
module piezo_seq #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 15,
  parameter int DUR_W    = 25,
  parameter int GAP_CYC  = 1024,
  parameter int GAP_W    = 16,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [PERIOD_W-1:0] wr_period,
  input  logic [DUR_W-1:0]    wr_dur,
  input  logic                start,
  input  logic [AW-1:0]       start_addr,
  input  logic [AW:0]         seq_len,
  input  logic                loop,
  input  logic                stop,
  output logic                busy,
  output logic                done,
  output logic [AW-1:0]       cur_addr,
  output logic                piezo_p,
  output logic                piezo_n
);

  typedef enum logic [1:0] {IDLE, LOAD, TONE, GAP} state_t;

  typedef struct packed {
    logic [PERIOD_W-1:0] period;
    logic [DUR_W-1:0]    dur;
  } tone_t;

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [AW:0]      REM_ONE  = (AW+1)'(1);

  tone_t               tone_tab [DEPTH];
  tone_t               ld_ent;
  state_t              state;
  logic [AW-1:0]       first_addr;
  logic [AW:0]         remaining;
  logic [AW:0]         seq_len_r;
  logic                loop_r;
  logic [PERIOD_W-1:0] period_r;
  logic [PERIOD_W-1:0] freq_tmr;
  logic [PERIOD_W-1:0] freq_nxt;
  logic [PERIOD_W-1:0] half_per;
  logic [DUR_W-1:0]    dur_r;
  logic [DUR_W-1:0]    note_tmr;
  logic [GAP_W-1:0]    gap_tmr;
  logic                rest;
  logic                note_last;
  logic                adv_now;

  assign ld_ent    = tone_tab[cur_addr];
  assign rest      = (period_r[PERIOD_W-1:1] == '0);
  assign half_per  = period_r >> 1;
  assign note_last = (note_tmr == dur_r - DUR_W'(1));
  // Rests hold the frequency timer at zero so period_r-1 never underflows.
  assign freq_nxt  = (rest || freq_tmr == period_r - PERIOD_W'(1)) ? '0 : freq_tmr + PERIOD_W'(1);
  assign adv_now   = (state == TONE && note_last && GAP_CYC == 0) ||
                     (state == GAP && gap_tmr == GAP_LAST);
  assign piezo_n   = ~piezo_p;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tone_tab[i] <= '0;
    end else if (wr_en) begin
      tone_tab[wr_addr] <= {wr_period, wr_dur};
    end
  end

  always_ff @(posedge clk) begin
    done <= 1'b0;
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      cur_addr   <= '0;
      first_addr <= '0;
      remaining  <= '0;
      seq_len_r  <= '0;
      loop_r     <= 1'b0;
      period_r   <= '0;
      dur_r      <= '0;
      freq_tmr   <= '0;
      note_tmr   <= '0;
      gap_tmr    <= '0;
      piezo_p    <= 1'b0;
    end else if (stop && state != IDLE) begin
      state   <= IDLE;
      busy    <= 1'b0;
      piezo_p <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && seq_len != '0) begin
            cur_addr   <= start_addr;
            first_addr <= start_addr;
            remaining  <= seq_len;
            seq_len_r  <= seq_len;
            loop_r     <= loop;
            busy       <= 1'b1;
            state      <= LOAD;
          end
        end
        LOAD: begin
          period_r <= ld_ent.period;
          dur_r    <= (ld_ent.dur == '0) ? DUR_W'(1) : ld_ent.dur;
          freq_tmr <= '0;
          note_tmr <= '0;
          piezo_p  <= 1'b0;
          state    <= TONE;
        end
        TONE: begin
          note_tmr <= note_tmr + DUR_W'(1);
          freq_tmr <= freq_nxt;
          piezo_p  <= !rest && (freq_nxt >= half_per);
          if (note_last) begin
            piezo_p <= 1'b0;
            if (GAP_CYC != 0) begin
              gap_tmr <= '0;
              state   <= GAP;
            end
          end
        end
        GAP: begin
          gap_tmr <= gap_tmr + GAP_W'(1);
        end
        default: state <= IDLE;
      endcase

      // End of note (after the gap if any): next entry, restart the pass, or finish.
      if (adv_now) begin
        if (remaining != REM_ONE) begin
          cur_addr  <= cur_addr + AW'(1);
          remaining <= remaining - REM_ONE;
          state     <= LOAD;
        end else if (loop_r) begin
          cur_addr  <= first_addr;
          remaining <= seq_len_r;
          state     <= LOAD;
        end else begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_piezo_seq.sv
// Bench for piezo_seq: two instances (gap 4 and no gap) share stimulus; each is checked per cycle against a trace model.
module tb_piezo_seq;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int PW    = 15;
  localparam int DW    = 25;

  typedef struct packed {
    logic          busy;
    logic          done;
    logic          p;
    logic          n;
    logic [AW-1:0] addr;
  } obs_t;

  typedef struct {
    int addr;
    int len;
    int busy4;
    int busy0;
    int high;
    int done;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, loop, stop;
  logic [AW-1:0] wr_addr, start_addr;
  logic [PW-1:0] wr_period;
  logic [DW-1:0] wr_dur;
  logic [AW:0]   seq_len;
  logic          busy4, done4, p4, n4, busy0, done0, p0, n0;
  logic [AW-1:0] addr4, addr0;

  obs_t q4[$], q0[$], tq[$];
  obs_t last4, last0, idle_o;
  int   mper[DEPTH], mdur[DEPTH];
  int   n_tests, n_fail;
  vec_t vt[6];

  always #5 clk = ~clk;

  piezo_seq #(.DEPTH(DEPTH), .PERIOD_W(PW), .DUR_W(DW), .GAP_CYC(4), .GAP_W(16)) u_dut4 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period),
    .wr_dur(wr_dur), .start(start), .start_addr(start_addr), .seq_len(seq_len),
    .loop(loop), .stop(stop), .busy(busy4), .done(done4), .cur_addr(addr4),
    .piezo_p(p4), .piezo_n(n4));

  piezo_seq #(.DEPTH(DEPTH), .PERIOD_W(PW), .DUR_W(DW), .GAP_CYC(0), .GAP_W(16)) u_dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_period(wr_period),
    .wr_dur(wr_dur), .start(start), .start_addr(start_addr), .seq_len(seq_len),
    .loop(loop), .stop(stop), .busy(busy0), .done(done0), .cur_addr(addr0),
    .piezo_p(p0), .piezo_n(n0));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, want 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_obs(input string name, input obs_t a, input obs_t e);
    if (!e.busy) begin
      a.addr = '0;
      e.addr = '0;
    end
    check(name, {25'd0, a}, {25'd0, e});
  endtask

  // Expected per-cycle trace of a melody, straight from the note rules.
  task automatic build(input int gap, input int a, input int len, input bit lp);
    obs_t o;
    int   ad, per, d;
    tq.delete();
    for (int ps = 0; ps < (lp ? 3 : 1); ps++) begin
      for (int k = 0; k < len; k++) begin
        ad  = (a + k) % DEPTH;
        per = mper[ad];
        d   = (mdur[ad] == 0) ? 1 : mdur[ad];
        o = idle_o;
        o.busy = 1'b1;
        o.addr = AW'(ad);
        tq.push_back(o);
        for (int i = 0; i < d; i++) begin
          o.p = (per >= 2) && ((i % per) >= per / 2);
          o.n = !o.p;
          tq.push_back(o);
        end
        o.p = 1'b0;
        o.n = 1'b1;
        for (int g = 0; g < gap; g++) tq.push_back(o);
      end
    end
    if (!lp) begin
      o = idle_o;
      o.done = 1'b1;
      tq.push_back(o);
    end
  endtask

  task automatic step();
    obs_t e;
    @(negedge clk);
    e = idle_o;
    if (q4.size() != 0) e = q4.pop_front();
    cmp_obs("trace_gap4", {busy4, done4, p4, n4, addr4}, e);
    last4 = e;
    e = idle_o;
    if (q0.size() != 0) e = q0.pop_front();
    cmp_obs("trace_gap0", {busy0, done0, p0, n0, addr0}, e);
    last0 = e;
    start = 1'b0;
    stop  = 1'b0;
    wr_en = 1'b0;
  endtask

  task automatic kick(input int a, input int len, input bit lp);
    start      = 1'b1;
    start_addr = AW'(a);
    seq_len    = (AW+1)'(len);
    loop       = lp;
    if (len != 0) begin
      if (!last4.busy) begin
        build(4, a, len, lp);
        foreach (tq[i]) q4.push_back(tq[i]);
      end
      if (!last0.busy) begin
        build(0, a, len, lp);
        foreach (tq[i]) q0.push_back(tq[i]);
      end
    end
  endtask

  task automatic stop_now();
    stop = 1'b1;
    if (last4.busy) q4.delete();
    if (last0.busy) q0.delete();
  endtask

  task automatic wr(input int a, input int per, input int dur);
    wr_en     = 1'b1;
    wr_addr   = AW'(a);
    wr_period = PW'(per);
    wr_dur    = DW'(dur);
    mper[a]   = per;
    mdur[a]   = dur;
  endtask

  task automatic run_idle();
    int c;
    c = 0;
    while ((q4.size() != 0 || q0.size() != 0) && c < 5000) begin
      step();
      c++;
    end
    step();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int a, len, m, sa, c;
    bit lp;
    int cb4, cb0, ch4, ch0, cd4, cd0;

    n_tests = 0;
    n_fail  = 0;
    idle_o  = '0;
    idle_o.n = 1'b1;
    last4 = idle_o;
    last0 = idle_o;
    for (int i = 0; i < DEPTH; i++) begin
      mper[i] = 0;
      mdur[i] = 0;
    end
    vt[0] = '{2, 1, 45, 41, 20, 1};
    vt[1] = '{6, 3, 44, 32, 12, 1};
    vt[2] = '{1, 1, 19, 15, 8, 1};
    vt[3] = '{3, 1, 6, 2, 0, 1};
    vt[4] = '{3, 0, 0, 0, 0, 0};
    vt[5] = '{7, 2, 23, 15, 4, 1};

    rst = 1'b1; start = 1'b1; start_addr = 3'd5; seq_len = 4'd1; loop = 1'b0;
    stop = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp_obs("rst_gap4", {busy4, done4, p4, n4, addr4}, idle_o);
      cmp_obs("rst_gap0", {busy0, done0, p0, n0, addr0}, idle_o);
      check("rst_addr4", {29'd0, addr4}, 0);
      check("rst_addr0", {29'd0, addr0}, 0);
    end
    rst = 1'b0;
    start = 1'b0;

    // Entry 0 straight out of reset is a one-cycle rest.
    kick(0, 1, 1'b0);
    run_idle();

    wr(2, 10, 40); step();
    wr(6, 8, 16);  step();
    wr(7, 0, 5);   step();
    wr(0, 4, 8);   step();
    wr(1, 7, 14);  step();
    wr(3, 7, 0);   step();

    for (int v = 0; v < 6; v++) begin
      run_idle();
      cb4 = 0; cb0 = 0; ch4 = 0; ch0 = 0; cd4 = 0; cd0 = 0;
      kick(vt[v].addr, vt[v].len, 1'b0);
      repeat (60) begin
        step();
        cb4 += int'(busy4); cb0 += int'(busy0);
        ch4 += int'(p4);    ch0 += int'(p0);
        cd4 += int'(done4); cd0 += int'(done0);
      end
      check($sformatf("vec%0d_busy_gap4", v), cb4, vt[v].busy4);
      check($sformatf("vec%0d_busy_gap0", v), cb0, vt[v].busy0);
      check($sformatf("vec%0d_high_gap4", v), ch4, vt[v].high);
      check($sformatf("vec%0d_high_gap0", v), ch0, vt[v].high);
      check($sformatf("vec%0d_done_gap4", v), cd4, vt[v].done);
      check($sformatf("vec%0d_done_gap0", v), cd0, vt[v].done);
    end

    // Loop of two notes: two full passes, back to the start address, then stop mid-tone.
    run_idle();
    kick(6, 2, 1'b1);
    repeat (66) step();
    stop_now();
    run_idle();

    // Start while busy is ignored.
    kick(2, 1, 1'b0);
    repeat (10) step();
    kick(6, 3, 1'b0);
    run_idle();

    // Rewriting the next entry during the current note changes what that note plays.
    wr(4, 6, 12); step();
    wr(5, 4, 8);  step();
    mper[5] = 10;
    mdur[5] = 10;
    kick(4, 2, 1'b0);
    repeat (5) step();
    wr(5, 10, 10);
    run_idle();

    // A write to the entry being loaded, in the LOAD cycle, is not seen by that note.
    kick(2, 1, 1'b0);
    step();
    wr(2, 6, 6);
    run_idle();
    kick(2, 1, 1'b0);
    run_idle();

    kick(1, 0, 1'b0);
    repeat (5) step();

    for (int it = 0; it < 40; it++) begin
      repeat ($urandom_range(0, 3)) begin
        wr($urandom_range(0, DEPTH - 1), $urandom_range(0, 12), $urandom_range(0, 12));
        step();
      end
      a   = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(0, DEPTH);
      lp  = ($urandom_range(0, 3) == 0);
      kick(a, len, lp);
      if (lp && len != 0) begin
        m  = (q4.size() < q0.size()) ? q4.size() : q0.size();
        sa = $urandom_range(1, m - 1);
        repeat (sa) step();
        stop_now();
      end else begin
        c = 0;
        while ((q4.size() != 0 || q0.size() != 0) && c < 2000) begin
          step();
          c++;
          if ($urandom_range(0, 39) == 0) stop_now();
          else if ($urandom_range(0, 29) == 0)
            kick($urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH), 1'b0);
        end
      end
      run_idle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
